// File: rtl/register_file_sb.sv
// Integer register file with two async read ports, one sync write port,
// a post-reset initialisation sweep, optional write-to-read bypass and a busy scoreboard.
module register_file_sb #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 5,
  parameter int                    SP_INDEX   = 2,
  parameter logic [DATA_WIDTH-1:0] SP_RESET   = DATA_WIDTH'(32'h7FFF_EFFC),
  parameter int                    GP_INDEX   = 3,
  parameter logic [DATA_WIDTH-1:0] GP_RESET   = DATA_WIDTH'(32'h1000_8000),
  parameter bit                    BYPASS     = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Reg_Write_i,
  input  logic [ADDR_WIDTH-1:0] Write_Register_i,
  input  logic [DATA_WIDTH-1:0] Write_Data_i,
  input  logic [ADDR_WIDTH-1:0] Read_Register_1_i,
  input  logic [ADDR_WIDTH-1:0] Read_Register_2_i,
  input  logic                  Reserve_i,
  input  logic [ADDR_WIDTH-1:0] Reserve_Register_i,
  output logic [DATA_WIDTH-1:0] Read_Data_1_o,
  output logic [DATA_WIDTH-1:0] Read_Data_2_o,
  output logic                  Busy_1_o,
  output logic                  Busy_2_o,
  output logic                  Ready_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   LAST_CNT = (ADDR_WIDTH+1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] SP_ADDR  = ADDR_WIDTH'(SP_INDEX);
  localparam logic [ADDR_WIDTH-1:0] GP_ADDR  = ADDR_WIDTH'(GP_INDEX);

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH:0]     cnt_q, cnt_d;
  logic                    ready_q;
  logic [DEPTH-1:0]        busy_q, busy_d;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  // ---------------------------------------------------------------------------
  // Sweep FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) state_d = RUN;
      end
      RUN: ;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q <= INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == RUN);
    end
  end

  assign Ready_o = ready_q;

  // ---------------------------------------------------------------------------
  // Single write port shared by the sweep and the writeback stage
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = Write_Register_i;
    mem_wdata = Write_Data_i;
    if (!reset) begin
      if (state_q == INIT) begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q[ADDR_WIDTH-1:0];
        if (cnt_q[ADDR_WIDTH-1:0] == SP_ADDR)      mem_wdata = SP_RESET;
        else if (cnt_q[ADDR_WIDTH-1:0] == GP_ADDR) mem_wdata = GP_RESET;
        else                                       mem_wdata = '0;
      end else begin
        mem_we = Reg_Write_i && (Write_Register_i != '0);
      end
    end
  end

  // NOTE: the array has no reset branch; the sweep initialises it, which keeps it mappable onto RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // ---------------------------------------------------------------------------
  // Busy scoreboard: clear on write, then set on reserve so a new producer wins
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_d = busy_q;
    if (state_q == RUN) begin
      if (Reg_Write_i)                                busy_d[Write_Register_i]   = 1'b0;
      if (Reserve_i && (Reserve_Register_i != '0))    busy_d[Reserve_Register_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] rd_addr [2];
  logic [DATA_WIDTH-1:0] rd_data [2];
  logic                  rd_busy [2];

  assign rd_addr[0] = Read_Register_1_i;
  assign rd_addr[1] = Read_Register_2_i;

  for (genvar p = 0; p < 2; p++) begin : g_read
    always_comb begin
      rd_data[p] = '0;
      rd_busy[p] = 1'b0;
      if ((state_q == RUN) && (rd_addr[p] != '0)) begin
        rd_data[p] = mem[rd_addr[p]];
        rd_busy[p] = busy_q[rd_addr[p]];
        if (BYPASS && Reg_Write_i && (Write_Register_i == rd_addr[p])) begin
          rd_data[p] = Write_Data_i;
          // A same-cycle re-reserve keeps the register pending, so show the stored flag.
          if (!(Reserve_i && (Reserve_Register_i == rd_addr[p]))) rd_busy[p] = 1'b0;
        end
      end
    end
  end

  assign Read_Data_1_o = rd_data[0];
  assign Read_Data_2_o = rd_data[1];
  assign Busy_1_o      = rd_busy[0];
  assign Busy_2_o      = rd_busy[1];

endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench for register_file_sb: one instance with bypass, one without, sharing stimulus.
module tb_register_file_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  ra1, ra2;
  logic        rsv;
  logic [4:0]  rsv_reg;

  logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
  logic        bz1_b, bz2_b, bz1_n, bz2_n;
  logic        rdy_b, rdy_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  register_file_sb #(.BYPASS(1'b1)) dut_b (
    .clk(clk), .reset(reset),
    .Reg_Write_i(we), .Write_Register_i(waddr), .Write_Data_i(wdata),
    .Read_Register_1_i(ra1), .Read_Register_2_i(ra2),
    .Reserve_i(rsv), .Reserve_Register_i(rsv_reg),
    .Read_Data_1_o(rd1_b), .Read_Data_2_o(rd2_b),
    .Busy_1_o(bz1_b), .Busy_2_o(bz2_b), .Ready_o(rdy_b)
  );

  register_file_sb #(.BYPASS(1'b0)) dut_n (
    .clk(clk), .reset(reset),
    .Reg_Write_i(we), .Write_Register_i(waddr), .Write_Data_i(wdata),
    .Read_Register_1_i(ra1), .Read_Register_2_i(ra2),
    .Reserve_i(rsv), .Reserve_Register_i(rsv_reg),
    .Read_Data_1_o(rd1_n), .Read_Data_2_o(rd2_n),
    .Busy_1_o(bz1_n), .Busy_2_o(bz2_n), .Ready_o(rdy_n)
  );

  task automatic idle();
    we = 1'b0; waddr = '0; wdata = '0;
    rsv = 1'b0; rsv_reg = '0;
  endtask

  // Counts edges until Ready_o of both instances is high; bounded at 40.
  task automatic wait_ready(input string name);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        checks++;
        if (rd1_b !== 32'h0 || bz1_b !== 1'b0 || rd1_n !== 32'h0) begin
          errors++;
          $display("FAIL %s_init_forced rd1_b=%h bz1_b=%b rd1_n=%h required 0", name, rd1_b, bz1_b, rd1_n);
        end
      end
    end while (!(rdy_b && rdy_n) && n < 40);
    checks++;
    if (n != 32 || rdy_b !== 1'b1 || rdy_n !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready_edges got %0d (rdy_b=%b rdy_n=%b) required 32", name, n, rdy_b, rdy_n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; idle(); ra1 = 5'd2; ra2 = 5'd3;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if (rdy_b !== 1'b0 || rd1_b !== 32'h0 || rd2_b !== 32'h0 || bz1_b !== 1'b0 || bz2_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_state rdy=%b rd1=%h rd2=%h bz=%b%b required all 0", rdy_b, rd1_b, rd2_b, bz1_b, bz2_b);
    end
    reset = 1'b0;
    wait_ready("reset");
  endtask

  task automatic test_sweep_values();
    @(negedge clk); ra1 = 5'd2; ra2 = 5'd3; #1;
    checks++;
    if (rd1_b !== 32'h7FFF_EFFC || rd2_b !== 32'h1000_8000) begin
      errors++;
      $display("FAIL sweep_sp_gp got %h %h required 7fffeffc 10008000", rd1_b, rd2_b);
    end
    ra1 = 5'd1; ra2 = 5'd31; #1;
    checks++;
    if (rd1_b !== 32'h0 || rd2_b !== 32'h0 || rd1_n !== 32'h0 || rd2_n !== 32'h0) begin
      errors++;
      $display("FAIL sweep_zero got %h %h %h %h required 0", rd1_b, rd2_b, rd1_n, rd2_n);
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF; ra1 = 5'd5; ra2 = 5'd5; #1;
    checks++;
    if (rd1_b !== 32'hDEAD_BEEF || rd2_b !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL bypass_same_cycle got %h %h required deadbeef", rd1_b, rd2_b);
    end
    checks++;
    if (rd1_n !== 32'h0) begin
      errors++;
      $display("FAIL nobypass_same_cycle got %h required 0", rd1_n);
    end
    @(negedge clk); idle(); #1;
    checks++;
    if (rd1_b !== 32'hDEAD_BEEF || rd1_n !== 32'hDEAD_BEEF || rd2_n !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL write_after_edge got %h %h %h required deadbeef", rd1_b, rd1_n, rd2_n);
    end
  endtask

  task automatic test_x0();
    @(negedge clk);
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; rsv = 1'b1; rsv_reg = 5'd0;
    ra1 = 5'd0; ra2 = 5'd0; #1;
    checks++;
    if (rd1_b !== 32'h0 || rd2_b !== 32'h0 || bz1_b !== 1'b0 || bz2_b !== 1'b0) begin
      errors++;
      $display("FAIL x0_same_cycle rd=%h %h bz=%b%b required 0", rd1_b, rd2_b, bz1_b, bz2_b);
    end
    @(negedge clk); idle(); #1;
    checks++;
    if (rd1_b !== 32'h0 || rd1_n !== 32'h0 || bz1_b !== 1'b0 || bz1_n !== 1'b0) begin
      errors++;
      $display("FAIL x0_after_edge rd=%h %h bz=%b%b required 0", rd1_b, rd1_n, bz1_b, bz1_n);
    end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    rsv = 1'b1; rsv_reg = 5'd7; ra1 = 5'd7; ra2 = 5'd2; #1;
    checks++;
    if (bz1_b !== 1'b0) begin
      errors++;
      $display("FAIL reserve_pre_edge busy=%b required 0", bz1_b);
    end
    @(negedge clk); idle(); #1;
    checks++;
    if (bz1_b !== 1'b1 || bz1_n !== 1'b1 || bz2_b !== 1'b0) begin
      errors++;
      $display("FAIL reserve_busy bz1_b=%b bz1_n=%b bz2_b=%b required 1 1 0", bz1_b, bz1_n, bz2_b);
    end
    we = 1'b1; waddr = 5'd7; wdata = 32'd5; #1;
    checks++;
    if (bz1_b !== 1'b0 || bz1_n !== 1'b1 || rd1_b !== 32'd5) begin
      errors++;
      $display("FAIL write_clear_same_cycle bz1_b=%b bz1_n=%b rd1_b=%h required 0 1 5", bz1_b, bz1_n, rd1_b);
    end
    @(negedge clk); idle(); #1;
    checks++;
    if (bz1_b !== 1'b0 || bz1_n !== 1'b0 || rd1_n !== 32'd5) begin
      errors++;
      $display("FAIL write_clear_after bz1_b=%b bz1_n=%b rd1_n=%h required 0 0 5", bz1_b, bz1_n, rd1_n);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    rsv = 1'b1; rsv_reg = 5'd7; ra1 = 5'd7; ra2 = 5'd7;
    @(negedge clk);
    we = 1'b1; waddr = 5'd7; wdata = 32'd9; #1;
    checks++;
    if (rd1_b !== 32'd9 || bz1_b !== 1'b1 || rd1_n !== 32'd5) begin
      errors++;
      $display("FAIL rsv_write_same_cycle rd1_b=%h bz1_b=%b rd1_n=%h required 9 1 5", rd1_b, bz1_b, rd1_n);
    end
    @(negedge clk); idle(); #1;
    checks++;
    if (rd1_b !== 32'd9 || rd2_n !== 32'd9 || bz1_b !== 1'b1 || bz2_n !== 1'b1) begin
      errors++;
      $display("FAIL rsv_write_set_wins rd=%h %h bz=%b%b required 9 9 1 1", rd1_b, rd2_n, bz1_b, bz2_n);
    end
  endtask

  task automatic test_reset_mid_sweep();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    we = 1'b1; waddr = 5'd9; wdata = 32'h0000_1234; rsv = 1'b1; rsv_reg = 5'd9;
    ra1 = 5'd9; ra2 = 5'd7;
    @(negedge clk); reset = 1'b0;
    wait_ready("mid_sweep");
    @(negedge clk); idle(); #1;
    checks++;
    if (rd1_b !== 32'h0 || rd1_n !== 32'h0 || bz1_b !== 1'b0 || bz1_n !== 1'b0) begin
      errors++;
      $display("FAIL init_ignored_x9 rd=%h %h bz=%b%b required 0", rd1_b, rd1_n, bz1_b, bz1_n);
    end
    checks++;
    if (rd2_b !== 32'h0 || bz2_b !== 1'b0 || bz2_n !== 1'b0) begin
      errors++;
      $display("FAIL resweep_x7 rd=%h bz=%b%b required 0", rd2_b, bz2_b, bz2_n);
    end
    ra1 = 5'd2; ra2 = 5'd5; #1;
    checks++;
    if (rd1_n !== 32'h7FFF_EFFC || rd2_b !== 32'h0) begin
      errors++;
      $display("FAIL resweep_values x2=%h x5=%h required 7fffeffc 0", rd1_n, rd2_b);
    end
  endtask

  initial begin
    test_reset();
    test_sweep_values();
    test_bypass();
    test_x0();
    test_scoreboard();
    test_back_to_back();
    test_reset_mid_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
